// File: rtl/swt16_mem_pkg.sv
// Shared constants and helpers for the swt16 memory models.
package swt16_mem_pkg;

    localparam int MIN_LAT = 1;
    localparam int MAX_LAT = 8;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;

    // Number of byte-offset bits below the word index.
    function automatic int addr_lsb(input int word_width);
        return $clog2(word_width / 8);
    endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Response pipeline: READ_LATENCY stages of {valid, err, data}, cleared asynchronously.
module mem_resp_pipe
    import swt16_mem_pkg::*;
#(
    parameter int WORD_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_err,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic                  out_err,
    output logic [WORD_WIDTH-1:0] out_data
);

    logic                  valid_q [READ_LATENCY];
    logic                  err_q   [READ_LATENCY];
    logic [WORD_WIDTH-1:0] data_q  [READ_LATENCY];

    // Stage 0 captures the sampled request; err/data are forced to 0 when not valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                valid_q[k] <= 1'b0;
                err_q[k]   <= 1'b0;
                data_q[k]  <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            err_q[0]   <= in_valid & in_err;
            data_q[0]  <= in_valid ? in_data : '0;
            for (int k = 1; k < READ_LATENCY; k++) begin
                valid_q[k] <= valid_q[k-1];
                err_q[k]   <= err_q[k-1];
                data_q[k]  <= data_q[k-1];
            end
        end
    end

    assign out_valid = valid_q[READ_LATENCY-1];
    assign out_err   = err_q[READ_LATENCY-1];
    assign out_data  = data_q[READ_LATENCY-1];

endmodule

// File: rtl/pmem_sim_dp.sv
// Dual-port simulation memory for swt16: read-only fetch port, byte-enabled data port,
// fixed read latency with misaligned/out-of-range error responses.
module pmem_sim_dp
    import swt16_mem_pkg::*;
#(
    parameter int    WORD_WIDTH   = 16,
    parameter int    ADDR_WIDTH   = 12,
    parameter int    NUM_WORDS    = 2048,
    parameter int    READ_LATENCY = 1,
    parameter string PMEM_FILE    = ""
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_rvalid,
    output logic [WORD_WIDTH-1:0]   i_rdata,
    output logic                    i_err,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [WORD_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [WORD_WIDTH-1:0]   d_wdata,
    output logic                    d_rvalid,
    output logic [WORD_WIDTH-1:0]   d_rdata,
    output logic                    d_err
);

    localparam int ADDR_LSB = addr_lsb(WORD_WIDTH);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int WIDX     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W:0] NUM_WORDS_C = (IDX_W + 1)'(NUM_WORDS);

    if (READ_LATENCY < MIN_LAT || READ_LATENCY > MAX_LAT) begin : g_bad_lat
        $error("pmem_sim_dp: READ_LATENCY must be in 1..8");
    end
    if (WORD_WIDTH % 8 != 0) begin : g_bad_width
        $error("pmem_sim_dp: WORD_WIDTH must be a multiple of 8");
    end
    if (NUM_WORDS > (1 << IDX_W)) begin : g_bad_depth
        $error("pmem_sim_dp: NUM_WORDS exceeds the addressable range");
    end

    logic [WORD_WIDTH-1:0] mem_q [NUM_WORDS];

    logic [1:0]            i_code_s, d_code_s;
    logic [WIDX-1:0]       i_widx_s, d_widx_s;
    logic [WORD_WIDTH-1:0] i_data_s, d_data_s;
    logic                  d_wr_s;

    assign i_widx_s = i_addr[ADDR_LSB +: WIDX];
    assign d_widx_s = d_addr[ADDR_LSB +: WIDX];

    // Address decode and read data; reads see the array before this edge's write.
    always_comb begin
        i_code_s = ERR_NONE;
        d_code_s = ERR_NONE;
        i_data_s = '0;
        d_data_s = '0;
        if (i_addr[ADDR_LSB-1:0] != '0) begin
            i_code_s = ERR_MISALIGN;
        end else if ({1'b0, i_addr[ADDR_WIDTH-1:ADDR_LSB]} >= NUM_WORDS_C) begin
            i_code_s = ERR_RANGE;
        end else begin
            i_data_s = mem_q[i_widx_s];
        end
        if (d_addr[ADDR_LSB-1:0] != '0) begin
            d_code_s = ERR_MISALIGN;
        end else if ({1'b0, d_addr[ADDR_WIDTH-1:ADDR_LSB]} >= NUM_WORDS_C) begin
            d_code_s = ERR_RANGE;
        end else if (!d_we) begin
            d_data_s = mem_q[d_widx_s];
        end else begin
            d_data_s = '0;
        end
    end

    assign d_wr_s = ~reset & d_req & d_we & (d_code_s == ERR_NONE);

    // Byte-enabled write; the array has no reset so contents survive it.
    always_ff @(posedge clock) begin
        if (d_wr_s) begin
            for (int b = 0; b < WORD_WIDTH / 8; b++) begin
                if (d_be[b]) mem_q[d_widx_s][8*b +: 8] <= d_wdata[8*b +: 8];
            end
        end
    end

    mem_resp_pipe #(.WORD_WIDTH(WORD_WIDTH), .READ_LATENCY(READ_LATENCY)) u_i_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (i_req),
        .in_err    (i_code_s != ERR_NONE),
        .in_data   (i_data_s),
        .out_valid (i_rvalid),
        .out_err   (i_err),
        .out_data  (i_rdata)
    );

    mem_resp_pipe #(.WORD_WIDTH(WORD_WIDTH), .READ_LATENCY(READ_LATENCY)) u_d_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (d_req),
        .in_err    (d_code_s != ERR_NONE),
        .in_data   (d_data_s),
        .out_valid (d_rvalid),
        .out_err   (d_err),
        .out_data  (d_rdata)
    );

endmodule

// File: tb/tb_pmem_sim_dp.sv
// Randomized bench for pmem_sim_dp against a word-array model with per-port expected-response queues.
module tb_pmem_sim_dp;

    localparam int WW  = 16;
    localparam int AW  = 13;
    localparam int NW  = 2048;
    localparam int LAT = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_rvalid;
    logic [WW-1:0] i_rdata;
    logic          i_err;
    logic          d_req;
    logic          d_we;
    logic [1:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [WW-1:0] d_wdata;
    logic          d_rvalid;
    logic [WW-1:0] d_rdata;
    logic          d_err;

    pmem_sim_dp #(
        .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .NUM_WORDS(NW), .READ_LATENCY(LAT), .PMEM_FILE("")
    ) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            due;
        logic          err;
        logic [WW-1:0] data;
    } rsp_t;

    rsp_t          iq[$];
    rsp_t          dq[$];
    logic [WW-1:0] mem_m [NW];
    int            cyc = 0;
    int            n_vec = 0;
    int            n_bad = 0;

    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, act, exp);
        end
    endtask

    function automatic bit addr_bad(input logic [AW-1:0] a);
        return (a % 2 != 0) || ((a / 2) >= NW);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return AW'($urandom_range(0, 63) * 2 + 1);
        if (r == 1) return AW'(4096 + $urandom_range(0, 2047) * 2);
        return AW'($urandom_range(0, 63) * 2);
    endfunction

    // One cycle of stimulus; the model predicts responses at the sampling edge.
    task automatic drive(input bit rst, input bit ir, input logic [AW-1:0] ia,
                         input bit dr, input bit we, input logic [1:0] be,
                         input logic [AW-1:0] da, input logic [WW-1:0] wd);
        rsp_t r;
        @(posedge clock);
        #1;
        reset = rst; i_req = ir; i_addr = ia;
        d_req = dr; d_we = we; d_be = be; d_addr = da; d_wdata = wd;
        if (rst) begin
            iq.delete();
            dq.delete();
        end else begin
            if (ir) begin
                r.due  = cyc + LAT;
                r.err  = addr_bad(ia);
                r.data = r.err ? 16'h0000 : mem_m[ia / 2];
                iq.push_back(r);
            end
            if (dr) begin
                r.due  = cyc + LAT;
                r.err  = addr_bad(da);
                r.data = (r.err || we) ? 16'h0000 : mem_m[da / 2];
                dq.push_back(r);
                if (we && !r.err) begin
                    if (be[0]) mem_m[da / 2][7:0]  = wd[7:0];
                    if (be[1]) mem_m[da / 2][15:8] = wd[15:8];
                end
            end
        end
    endtask

    task automatic idle(input bit rst);
        drive(rst, 1'b0, 13'h0000, 1'b0, 1'b0, 2'b00, 13'h0000, 16'h0000);
    endtask

    bit   ev_i, ev_d;
    rsp_t ri, rd;

    // Response checker, away from the active edge.
    always @(negedge clock) begin
        ev_i = (iq.size() > 0) && (iq[0].due == cyc);
        chk("i_rvalid", 32'(i_rvalid), 32'(ev_i));
        if (ev_i) begin
            ri = iq.pop_front();
            chk("i_rdata", 32'(i_rdata), 32'(ri.data));
            chk("i_err", 32'(i_err), 32'(ri.err));
        end else begin
            chk("i_rdata_idle", 32'(i_rdata), 32'h0);
            chk("i_err_idle", 32'(i_err), 32'h0);
        end
        ev_d = (dq.size() > 0) && (dq[0].due == cyc);
        chk("d_rvalid", 32'(d_rvalid), 32'(ev_d));
        if (ev_d) begin
            rd = dq.pop_front();
            chk("d_rdata", 32'(d_rdata), 32'(rd.data));
            chk("d_err", 32'(d_err), 32'(rd.err));
        end else begin
            chk("d_rdata_idle", 32'(d_rdata), 32'h0);
            chk("d_err_idle", 32'(d_err), 32'h0);
        end
    end

    initial begin
        int budget;
        reset = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        repeat (3) idle(1'b1);
        // first request right after release, then fill words 0..63
        for (int w = 0; w < 64; w++)
            drive(1'b0, 1'b0, 13'h0000, 1'b1, 1'b1, 2'b11, AW'(w * 2), 16'($urandom));

        // partial byte write
        drive(1'b0, 1'b0, 13'h0000, 1'b1, 1'b1, 2'b11, 13'h0010, 16'h1111);
        drive(1'b0, 1'b0, 13'h0000, 1'b1, 1'b1, 2'b01, 13'h0010, 16'hBEEF);
        drive(1'b0, 1'b0, 13'h0000, 1'b1, 1'b0, 2'b00, 13'h0010, 16'h0000);
        // same-edge fetch/write collision, then fetch of the new word
        drive(1'b0, 1'b0, 13'h0000, 1'b1, 1'b1, 2'b11, 13'h0020, 16'h7777);
        drive(1'b0, 1'b1, 13'h0020, 1'b1, 1'b1, 2'b11, 13'h0020, 16'h5555);
        drive(1'b0, 1'b1, 13'h0020, 1'b0, 1'b0, 2'b00, 13'h0000, 16'h0000);
        // misaligned write and out-of-range fetch, then confirm word unchanged
        drive(1'b0, 1'b1, 13'h1000, 1'b1, 1'b1, 2'b11, 13'h0011, 16'hDEAD);
        drive(1'b0, 1'b1, 13'h0010, 1'b0, 1'b0, 2'b00, 13'h0000, 16'h0000);
        drive(1'b0, 1'b1, 13'h000A, 1'b1, 1'b0, 2'b00, 13'h0012, 16'h0000);
        // read in flight, reset for two cycles with ignored requests, then read again
        drive(1'b0, 1'b1, 13'h0000, 1'b1, 1'b0, 2'b00, 13'h0002, 16'h0000);
        drive(1'b1, 1'b1, 13'h0004, 1'b1, 1'b1, 2'b11, 13'h0004, 16'hCAFE);
        drive(1'b1, 1'b1, 13'h0006, 1'b1, 1'b1, 2'b11, 13'h0006, 16'hF00D);
        drive(1'b0, 1'b1, 13'h0004, 1'b1, 1'b0, 2'b00, 13'h0006, 16'h0000);

        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                idle(1'b1);
            end else begin
                drive(1'b0, 1'($urandom), rand_addr(), 1'($urandom), 1'($urandom),
                      2'($urandom), rand_addr(), 16'($urandom));
            end
        end

        budget = 0;
        while ((iq.size() > 0 || dq.size() > 0) && budget < 20) begin
            idle(1'b0);
            budget++;
        end
        idle(1'b0);
        chk("drain_i", 32'(iq.size()), 32'h0);
        chk("drain_d", 32'(dq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
